// File: rtl/fanout_fork_if.sv
`default_nettype none
// ============================================================================
// Module  : fanout_fork_if
// Purpose : Upstream ready/valid stream plus per-branch fanout handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface fanout_fork_if #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [NUM_OUT-1:0]    out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]    out_ready;

    // master: the fork itself; slave: the upstream producer plus the branch consumers
    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface
`default_nettype wire

// File: rtl/fanout_fork.sv
`default_nettype none
// ============================================================================
// Module  : fanout_fork
// Purpose : Broadcasts each upstream token to the enabled branches and retires
//           it once every branch has accepted it.
// Revision: 1.0 - initial release
// ============================================================================
module fanout_fork #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [NUM_OUT-1:0]   branch_en,
    fanout_fork_if.master             bus,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      tok_count
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [NUM_OUT-1:0]    pend_q,  pend_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

    logic [NUM_OUT-1:0]    w_out_valid;
    logic [NUM_OUT-1:0]    w_fire;
    logic [NUM_OUT-1:0]    w_left;
    logic                  w_retire;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_any_en;
    logic                  w_load;
    logic                  w_drop;

    assign w_out_valid = {NUM_OUT{valid_q}} & pend_q;
    assign w_fire      = w_out_valid & bus.out_ready;
    assign w_left      = pend_q & ~w_fire;
    assign w_retire    = valid_q & (w_left == '0);
    // Ready looks through to out_ready so a finishing token and a new one share an edge
    assign w_in_ready  = ~valid_q | w_retire;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_any_en    = |branch_en;
    assign w_load      = w_accept & w_any_en;
    assign w_drop      = w_accept & ~w_any_en;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pend_d  = pend_q;
        if (w_load) begin
            valid_d = 1'b1;
            data_d  = bus.in_data;
            pend_d  = branch_en;
        end else if (w_retire) begin
            valid_d = 1'b0;
            pend_d  = '0;
        end else begin
            pend_d  = w_left;
        end
    end

    // A retiring token and a dropped token in the same cycle are two finished tokens
    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(w_retire) + CNT_WIDTH'(w_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = data_q;
    assign busy          = valid_q;
    assign tok_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fanout_fork.sv
`default_nettype none
// ============================================================================
// Module  : tb_fanout_fork
// Purpose : Directed self-checking bench for fanout_fork (9 branches, plus a
//           4-bit counter instance sharing the same stimulus).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fanout_fork;

    logic        clk;
    logic        rst_n;
    logic [8:0]  branch_en;
    logic        in_valid;
    logic [15:0] in_data;
    logic [8:0]  out_ready;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int vec_cnt;
    int err_cnt;

    fanout_fork_if #(.NUM_OUT(9), .DATA_WIDTH(16)) ifa ();
    fanout_fork_if #(.NUM_OUT(9), .DATA_WIDTH(16)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    fanout_fork #(.NUM_OUT(9), .DATA_WIDTH(16), .CNT_WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .branch_en (branch_en),
        .bus       (ifa),
        .busy      (busy_a),
        .tok_count (cnt_a)
    );

    fanout_fork #(.NUM_OUT(9), .DATA_WIDTH(16), .CNT_WIDTH(4)) u_dut_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .branch_en (branch_en),
        .bus       (ifb),
        .busy      (busy_b),
        .tok_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 9'h0;
        branch_en = 9'h0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h0) begin
            err_cnt++; $display("FAIL reset_out_valid: got %h expected %h", ifa.out_valid, 9'h0);
        end
        vec_cnt++;
        if (ifa.out_data !== 16'h0) begin
            err_cnt++; $display("FAIL reset_out_data: got %h expected %h", ifa.out_data, 16'h0);
        end
        vec_cnt++;
        if (busy_a !== 1'b0 || cnt_a !== 16'h0) begin
            err_cnt++; $display("FAIL reset_busy_cnt: got busy=%b cnt=%h expected busy=0 cnt=0", busy_a, cnt_a);
        end
        vec_cnt++;
        if (ifa.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        do_reset();
        branch_en = 9'h1FF;
        out_ready = 9'h1FF;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            in_valid = (k < 10);
            in_data  = 16'(k);
            #1;
            if (k < 10) begin
                vec_cnt++;
                if (ifa.in_ready !== 1'b1) begin
                    err_cnt++; $display("FAIL full_rate_in_ready[%0d]: got %b expected 1", k, ifa.in_ready);
                end
            end
            if (k > 0) begin
                vec_cnt++;
                if (ifa.out_valid !== 9'h1FF || ifa.out_data !== 16'(k - 1)) begin
                    err_cnt++;
                    $display("FAIL full_rate_out[%0d]: got valid=%h data=%h expected valid=1ff data=%h",
                             k, ifa.out_valid, ifa.out_data, 16'(k - 1));
                end
            end
        end
        @(negedge clk);
        #1;
        vec_cnt++;
        if (cnt_a !== 16'd10 || ifa.out_valid !== 9'h0) begin
            err_cnt++; $display("FAIL full_rate_count: got cnt=%0d valid=%h expected cnt=10 valid=000", cnt_a, ifa.out_valid);
        end
    endtask

    task automatic test_staggered();
        logic [8:0] rdy_tab [1:5];
        logic [8:0] vld_tab [1:5];
        logic       irdy_tab[1:5];
        rdy_tab  = '{9'h001, 9'h000, 9'h004, 9'h000, 9'h002};
        vld_tab  = '{9'h007, 9'h006, 9'h006, 9'h002, 9'h002};
        irdy_tab = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
        do_reset();
        branch_en = 9'h007;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = rdy_tab[c];
            #1;
            vec_cnt++;
            if (ifa.out_valid !== vld_tab[c] || ifa.in_ready !== irdy_tab[c] || ifa.out_data !== 16'hABCD) begin
                err_cnt++;
                $display("FAIL staggered_cyc%0d: got valid=%h in_ready=%b data=%h expected valid=%h in_ready=%b data=abcd",
                         c, ifa.out_valid, ifa.in_ready, ifa.out_data, vld_tab[c], irdy_tab[c]);
            end
            vec_cnt++;
            if (cnt_a !== 16'd0) begin
                err_cnt++; $display("FAIL staggered_cnt_cyc%0d: got %0d expected 0", c, cnt_a);
            end
        end
        @(negedge clk);
        out_ready = 9'h0;
        #1;
        vec_cnt++;
        if (cnt_a !== 16'd1 || ifa.out_valid !== 9'h0 || busy_a !== 1'b0) begin
            err_cnt++; $display("FAIL staggered_retire: got cnt=%0d valid=%h busy=%b expected cnt=1 valid=000 busy=0",
                                cnt_a, ifa.out_valid, busy_a);
        end
    endtask

    task automatic test_disabled_sink();
        do_reset();
        branch_en = 9'h000;
        out_ready = 9'h000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(k);
            #1;
            vec_cnt++;
            if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 9'h0 || busy_a !== 1'b0) begin
                err_cnt++; $display("FAIL sink_tok%0d: got in_ready=%b valid=%h busy=%b expected 1/000/0",
                                    k, ifa.in_ready, ifa.out_valid, busy_a);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec_cnt++;
        if (cnt_a !== 16'd4) begin
            err_cnt++; $display("FAIL sink_count: got %0d expected 4", cnt_a);
        end
    endtask

    task automatic test_config_change();
        do_reset();
        branch_en = 9'h003;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        @(negedge clk);
        in_valid  = 1'b0;
        branch_en = 9'h004;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h003) begin
            err_cnt++; $display("FAIL cfg_hold: got %h expected 003", ifa.out_valid);
        end
        @(negedge clk);
        out_ready = 9'h1FF;
        in_valid  = 1'b1;
        in_data   = 16'h2222;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h003 || ifa.out_data !== 16'h1111 || ifa.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL cfg_first: got valid=%h data=%h in_ready=%b expected 003/1111/1",
                                ifa.out_valid, ifa.out_data, ifa.in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h004 || ifa.out_data !== 16'h2222) begin
            err_cnt++; $display("FAIL cfg_second: got valid=%h data=%h expected 004/2222", ifa.out_valid, ifa.out_data);
        end
        @(negedge clk);
        out_ready = 9'h0;
        #1;
        vec_cnt++;
        if (cnt_a !== 16'd2 || ifa.out_valid !== 9'h0) begin
            err_cnt++; $display("FAIL cfg_count: got cnt=%0d valid=%h expected 2/000", cnt_a, ifa.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        // Continues from the previous test so the counter is non-zero going in
        branch_en = 9'h003;
        out_ready = 9'h000;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 9'h001;
        @(negedge clk);
        out_ready = 9'h000;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h002 || busy_a !== 1'b1) begin
            err_cnt++; $display("FAIL mid_pending: got valid=%h busy=%b expected 002/1", ifa.out_valid, busy_a);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h0 || ifa.out_data !== 16'h0 || busy_a !== 1'b0 ||
            cnt_a !== 16'h0 || ifa.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL mid_reset: got valid=%h data=%h busy=%b cnt=%0d in_ready=%b expected 000/0000/0/0/1",
                                ifa.out_valid, ifa.out_data, busy_a, cnt_a, ifa.in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        branch_en = 9'h002;
        out_ready = 9'h002;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vec_cnt++;
        if (ifa.out_valid !== 9'h002 || ifa.out_data !== 16'h0055 || ifa.in_ready !== 1'b1) begin
            err_cnt++; $display("FAIL mid_after: got valid=%h data=%h in_ready=%b expected 002/0055/1",
                                ifa.out_valid, ifa.out_data, ifa.in_ready);
        end
        @(negedge clk);
        #1;
        vec_cnt++;
        if (cnt_a !== 16'd1 || ifa.out_valid !== 9'h0) begin
            err_cnt++; $display("FAIL mid_count: got cnt=%0d valid=%h expected 1/000", cnt_a, ifa.out_valid);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        branch_en = 9'h1FF;
        out_ready = 9'h1FF;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        vec_cnt++;
        if (cnt_b !== 4'd1) begin
            err_cnt++; $display("FAIL wrap_cnt4: got %0d expected 1", cnt_b);
        end
        vec_cnt++;
        if (cnt_a !== 16'd17) begin
            err_cnt++; $display("FAIL wrap_cnt16: got %0d expected 17", cnt_a);
        end
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        branch_en = 9'h0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 9'h0;
        test_reset();
        test_full_rate();
        test_staggered();
        test_disabled_sink();
        test_config_change();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
